// File: rtl/alu_rsp_pkg.sv
//------------------------------------------------------------------------------
// Module : alu_rsp_pkg
// Brief  : Shared types and constants for the ALU response serializer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_rsp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_LSB  = 2'd2,
    ST_MSB  = 2'd3
  } rsp_state_t;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  function automatic int unsigned data_bytes(input int unsigned out_wd);
    return out_wd / 8;
  endfunction

  function automatic int unsigned bytes_per_result(input int unsigned out_wd, input bit tag_en);
    return data_bytes(out_wd) + (tag_en ? 1 : 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_rsp_serializer_if.sv
//------------------------------------------------------------------------------
// Module : alu_rsp_serializer_if
// Brief  : ALU result input and UART byte-stream output bundle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface alu_rsp_serializer_if #(
  parameter int OUT_WD = 16,
  parameter int FUN_WD = 4
);
  logic [OUT_WD-1:0] ALU_OUT;
  logic              OUT_VALID;
  logic [FUN_WD-1:0] ALU_FUN;
  logic [7:0]        TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic              DROP;
  logic              EMPTY;

  modport master (
    output ALU_OUT, OUT_VALID, ALU_FUN, TX_READY,
    input  TX_DATA, TX_VALID, DROP, EMPTY
  );

  modport slave (
    input  ALU_OUT, OUT_VALID, ALU_FUN, TX_READY,
    output TX_DATA, TX_VALID, DROP, EMPTY
  );
endinterface

`default_nettype wire

// File: rtl/alu_rsp_fifo.sv
//------------------------------------------------------------------------------
// Module : alu_rsp_fifo
// Brief  : Synchronous FIFO, extra pointer bit separates full from empty.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_rsp_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire              CLK,
  input  wire              RST,
  input  wire              push,
  input  wire              pop,
  input  wire  [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wptr;
  logic [c_aw:0]    r_rptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                 (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
  assign rdata = r_mem[r_rptr[c_aw-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push_ok) r_mem[r_wptr[c_aw-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/alu_rsp_serializer.sv
//------------------------------------------------------------------------------
// Module : alu_rsp_serializer
// Brief  : Queues ALU results and streams them LSB-first as bytes to the UART.
//          Optional TAG byte per result when ALU_RSP_TAG_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_rsp_serializer
  import alu_rsp_pkg::*;
#(
  parameter int OUT_WD = 16,
  parameter int FUN_WD = 4,
  parameter int DEPTH  = 4
) (
  input wire               CLK,
  input wire               RST,
  alu_rsp_serializer_if.slave bus
);

`ifdef ALU_RSP_TAG_EN
  localparam int c_ent_wd = FUN_WD + OUT_WD;
`else
  localparam int c_ent_wd = OUT_WD;
`endif
  localparam int unsigned c_data_bytes = data_bytes(OUT_WD);

  logic [c_ent_wd-1:0] w_wdata;
  logic [c_ent_wd-1:0] w_rdata;
  logic [OUT_WD-1:0]   w_rd_out;
  logic [7:0]          w_first_byte;
  rsp_state_t          w_first_state;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_xfer;
  logic                w_last;

  rsp_state_t          r_state;
  logic [15:0]         r_hold;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_drop;
  logic                r_empty;

`ifdef ALU_RSP_TAG_EN
  assign w_wdata       = {bus.ALU_FUN, bus.ALU_OUT};
  assign w_rd_out      = w_rdata[OUT_WD-1:0];
  assign w_first_byte  = {TAG_NIBBLE, 4'(w_rdata[c_ent_wd-1:OUT_WD])};
  assign w_first_state = ST_TAG;
`else
  logic w_unused_fun;
  assign w_unused_fun  = ^bus.ALU_FUN;
  assign w_wdata       = bus.ALU_OUT;
  assign w_rd_out      = w_rdata;
  assign w_first_byte  = w_rdata[7:0];
  assign w_first_state = ST_LSB;
`endif

  assign w_xfer = r_tx_valid && bus.TX_READY;
  assign w_last = (r_state == ST_MSB) || ((r_state == ST_LSB) && (c_data_bytes == 1));
  // Pop either from IDLE or back-to-back with the last byte, so there is no bubble.
  assign w_pop  = !w_empty && ((r_state == ST_IDLE) || (w_xfer && w_last));

  alu_rsp_fifo #(
    .WIDTH (c_ent_wd),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (bus.OUT_VALID),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_hold     <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_drop     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      r_drop  <= bus.OUT_VALID && w_full && !w_pop;
      // The FSM only lands in IDLE with the FIFO drained, so only a new push can clear EMPTY.
      r_empty <= !bus.OUT_VALID && w_empty &&
                 ((r_state == ST_IDLE) || (w_xfer && w_last));
      if (w_pop) begin
        r_hold     <= 16'(w_rd_out);
        r_tx_data  <= w_first_byte;
        r_tx_valid <= 1'b1;
        r_state    <= w_first_state;
      end else if (w_xfer) begin
        case (r_state)
          ST_TAG: begin
            r_tx_data <= r_hold[7:0];
            r_state   <= ST_LSB;
          end
          ST_LSB: begin
            if (w_last) begin
              r_tx_valid <= 1'b0;
              r_state    <= ST_IDLE;
            end else begin
              r_tx_data <= r_hold[15:8];
              r_state   <= ST_MSB;
            end
          end
          default: begin
            r_tx_valid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.TX_DATA  = r_tx_data;
  assign bus.TX_VALID = r_tx_valid;
  assign bus.DROP     = r_drop;
  assign bus.EMPTY    = r_empty;

endmodule

`default_nettype wire

// File: tb/tb_alu_rsp_serializer.sv
//------------------------------------------------------------------------------
// Module : tb_alu_rsp_serializer
// Brief  : Scoreboard bench for alu_rsp_serializer (honours ALU_RSP_TAG_EN).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_rsp_serializer;
  import alu_rsp_pkg::*;

  localparam int OUT_WD = 16;
  localparam int FUN_WD = 4;
  localparam int DEPTH  = 4;
`ifdef ALU_RSP_TAG_EN
  localparam bit         TAG        = 1'b1;
  localparam logic [7:0] FIRST_1234 = 8'hA0;
`else
  localparam bit         TAG        = 1'b0;
  localparam logic [7:0] FIRST_1234 = 8'h34;
`endif
  localparam int BPR = int'(bytes_per_result(OUT_WD, TAG));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_rsp_serializer_if #(.OUT_WD(OUT_WD), .FUN_WD(FUN_WD)) bus ();

  alu_rsp_serializer #(
    .OUT_WD (OUT_WD),
    .FUN_WD (FUN_WD),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts of queued results and bytes left in the current result.
  int         m_fifo_n   = 0;
  int         m_inflight = 0;
  logic [7:0] m_exp[$];
  bit         p_valid = 1'b0;
  bit         p_drop  = 1'b0;
  bit         p_empty = 1'b1;
  bit         m_xfer, m_pop, m_acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo_n   = 0;
      m_inflight = 0;
      m_exp.delete();
      p_valid = 1'b0;
      p_drop  = 1'b0;
      p_empty = 1'b1;
    end else begin
      m_xfer = (m_inflight > 0) && bus.TX_READY;
      if (m_xfer) m_inflight--;
      m_pop = (m_fifo_n > 0) && (m_inflight == 0);
      m_acc = bus.OUT_VALID && ((m_fifo_n < DEPTH) || m_pop);
      if (m_pop) begin
        m_fifo_n--;
        m_inflight = BPR;
      end
      if (m_acc) begin
        m_fifo_n++;
        if (TAG) m_exp.push_back({TAG_NIBBLE, 4'(bus.ALU_FUN)});
        m_exp.push_back(bus.ALU_OUT[7:0]);
        if (OUT_WD == 16) m_exp.push_back(bus.ALU_OUT[15:8]);
      end
      p_drop  = bus.OUT_VALID && !m_acc;
      p_valid = (m_inflight > 0);
      p_empty = (m_inflight == 0) && (m_fifo_n == 0);
    end
  end

  // Monitor: sampled mid-cycle, when inputs and outputs both reflect the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", bus.TX_VALID, 0);
      chk("rst_data",  bus.TX_DATA,  0);
      chk("rst_drop",  bus.DROP,     0);
      chk("rst_empty", bus.EMPTY,    1);
    end else begin
      chk("tx_valid", bus.TX_VALID, p_valid);
      chk("drop",     bus.DROP,     p_drop);
      chk("empty",    bus.EMPTY,    p_empty);
      if (bus.TX_VALID) begin
        if (m_exp.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_extra: got byte %0h want no byte at %0t", bus.TX_DATA, $time);
        end else begin
          chk("tx_data", bus.TX_DATA, m_exp[0]);
          if (bus.TX_READY) void'(m_exp.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit ov, input logic [OUT_WD-1:0] d,
                       input logic [FUN_WD-1:0] f, input bit rdy);
    bus.OUT_VALID = ov;
    bus.ALU_OUT   = d;
    bus.ALU_FUN   = f;
    bus.TX_READY  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) drive(1'b0, '0, '0, rdy);
  endtask

  int         n_drop;
  logic [31:0] rnd;
  int         rp;

  initial begin
    bus.OUT_VALID = 1'b0;
    bus.ALU_OUT   = '0;
    bus.ALU_FUN   = '0;
    bus.TX_READY  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    // Single result: first byte visible after the second edge.
    drive(1'b1, 16'h1234, 4'h0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    chk("lat_first", {bus.TX_VALID, bus.TX_DATA}, {1'b1, FIRST_1234});
    idle(5, 1'b1);
    chk("single_empty", bus.EMPTY, 1);

    // Backpressure on a held byte.
    drive(1'b1, 16'hBEEF, 4'h1, 1'b0);
    idle(5, 1'b0);
    idle(5, 1'b1);

    // Overflow: one held plus DEPTH queued, the sixth drops.
    n_drop = 0;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, OUT_WD'(i), FUN_WD'(i), 1'b0);
      n_drop += int'(bus.DROP);
    end
    repeat (2) begin
      drive(1'b0, '0, '0, 1'b0);
      n_drop += int'(bus.DROP);
    end
    chk("drop_once", n_drop, 1);
    idle(20, 1'b1);

    // Push on full coincident with the final handshake of the held result.
    for (int i = 0; i < 5; i++) drive(1'b1, OUT_WD'(16'h1100 + i), 4'h3, 1'b0);
    idle(BPR - 1, 1'b1);
    drive(1'b1, 16'h7777, 4'h4, 1'b1);
    chk("full_pop_nodrop", bus.DROP, 0);
    drive(1'b1, 16'h8888, 4'h5, 1'b0);
    chk("still_full_drop", bus.DROP, 1);
    idle(20, 1'b1);

    // Reset while the MSB of 0x5678 is pending.
    drive(1'b1, 16'h5678, 4'h6, 1'b0);
    drive(1'b0, '0, '0, 1'b0);
    idle(BPR - 1, 1'b1);
    chk("pre_rst_msb", {bus.TX_VALID, bus.TX_DATA}, {1'b1, 8'h56});
    bus.TX_READY = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.TX_VALID, 0);
    chk("rst_async_empty", bus.EMPTY, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    idle(6, 1'b1);

`ifdef ALU_RSP_TAG_EN
    drive(1'b1, 16'h00C8, 4'b0010, 1'b1);
    idle(6, 1'b1);
`endif

    // Randomised traffic under varying backpressure.
    for (int p = 0; p < 6; p++) begin
      case (p % 3)
        0:       rp = 20;
        1:       rp = 60;
        default: rp = 100;
      endcase
      for (int c = 0; c < 100; c++) begin
        rnd = $urandom;
        drive($urandom_range(0, 99) < 50, rnd[OUT_WD-1:0], rnd[OUT_WD+FUN_WD-1:OUT_WD],
              $urandom_range(0, 99) < rp);
      end
    end
    idle(40, 1'b1);
    chk("drain_left", m_exp.size(), 0);
    chk("end_empty", bus.EMPTY, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_rsp_serializer.md
# alu_rsp_serializer

Downstream stage of the ALU. Captures every registered result (`ALU_OUT` qualified by `OUT_VALID`) into a small FIFO. Each result is then streamed out as bytes, least-significant byte first, over a valid/ready handshake into the UART transmitter. It decouples the ALU, which produces one result per enabled cycle, from the much slower serial link.

## Interface
Parameters:
- `OUT_WD`, 16: ALU result width; legal values are 8 and 16.
- `FUN_WD`, 4: ALU function-code width.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `ALU_OUT`  in  `OUT_WD`  registered ALU result.
- `OUT_VALID`  in  1  result qualifier; each high cycle is one result.
- `ALU_FUN`  in  `FUN_WD`  function code aligned with `ALU_OUT`; used only when tagging is compiled in.
- `TX_DATA`  out  8  byte to the UART transmitter.
- `TX_VALID`  out  1  `TX_DATA` is valid.
- `TX_READY`  in  1  transmitter accepts the byte this cycle.
- `DROP`  out  1  one-cycle pulse: an incoming result was discarded because the FIFO was full.
- `EMPTY`  out  1  FIFO empty and no byte pending.

## Operation
- **Push:** on each edge where `OUT_VALID`=1, the entry {`ALU_FUN`, `ALU_OUT`} is written to the FIFO if it is not full.
- **Full:** a push into a full FIFO is discarded, the FIFO is unchanged, and `DROP`=1 for the next cycle. Exception: if a pop occurs on the same edge, the push is accepted and `DROP` stays 0.
- **FIFO:** occupancy is 0..`DEPTH`. Read and write pointers wrap modulo `DEPTH`. Full and empty are distinguished by an extra pointer bit.
- **FSM states:** IDLE, TAG, LSB, MSB.
- **IDLE → first byte:** in IDLE with the FIFO non-empty, pop the head into a holding register, drive the first byte with `TX_VALID`=1, and go to TAG (when tagging is compiled in) or LSB.
- **Byte transfer:** a byte transfers on an edge with `TX_VALID`&&`TX_READY`. The FSM then advances TAG→LSB→MSB.
- **Last byte:** MSB is the last byte; when `OUT_WD`=8, LSB is the last byte. On transfer of the last byte:
  - if the FIFO is non-empty, pop the next entry on the same edge and go straight to its first byte (no bubble);
  - otherwise go to IDLE with `TX_VALID`=0.
- **Byte values:** LSB = `ALU_OUT[7:0]`; MSB = `ALU_OUT[15:8]`.
- **Backpressure:** while `TX_VALID`=1 and `TX_READY`=0, `TX_DATA` and the state hold stable. `TX_VALID` never drops without a transfer.
- **`EMPTY`:** 1 when the FIFO is empty and the FSM is in IDLE.

## Timing
- **Reset values:** `TX_DATA`=0, `TX_VALID`=0, `DROP`=0, `EMPTY`=1, FIFO empty, FSM in IDLE. All are asynchronous on `RST`.
- **Reset mid-operation:** the byte in flight and all queued results are lost, and the same reset values apply.
- **All outputs are registered.**
- **Latency:** `OUT_VALID` sampled on edge 0 → FIFO non-empty after edge 0 → pop on edge 1 → `TX_VALID`=1 with the first byte after edge 1.
- **Throughput:** one byte per cycle when `TX_READY` is held at 1.
- **Simultaneous push and pop on a non-full FIFO:** occupancy is unchanged.

## Configuration
- **Macro `ALU_RSP_TAG_EN`.**
- **Defined:** the FIFO stores `FUN_WD`+`OUT_WD` bits per entry. Each result is preceded by the TAG byte {4'hA, `ALU_FUN`} (the function code zero-extended to 4 bits), giving 3 bytes per result for `OUT_WD`=16.
- **Undefined:** the FIFO stores `OUT_WD` bits, the TAG state is never entered, `ALU_FUN` is ignored, and each result is 2 bytes for `OUT_WD`=16.

## Structure
- **Package `alu_rsp_pkg`:** holds
  - the FSM state encoding (IDLE, TAG, LSB, MSB);
  - `TAG_NIBBLE`=4'hA;
  - the bytes-per-result constant derived from `OUT_WD`.
- **Sub-module `alu_rsp_fifo`:** parameterised width/depth synchronous FIFO.
  - Ports: push, pop, wdata, rdata, full, empty; same `CLK`/`RST`.
  - The top level contains the FSM, holding register and `DROP` logic.

## Test plan
- **Single result:** `TX_READY`=1, one `OUT_VALID` with `ALU_OUT`=0x1234 → `TX_DATA`=0x34 in cycle 2, 0x12 in cycle 3, then `TX_VALID`=0 and `EMPTY`=1.
- **Backpressure:** `ALU_OUT`=0xBEEF, `TX_READY` low for 5 cycles → 0xEF held stable with `TX_VALID`=1; after `TX_READY` rises, 0xEF then 0xBE.
- **Overflow:** `DEPTH`=4, `TX_READY`=0, five consecutive `OUT_VALID` carrying results 1..5 → the first is popped into the holding register, results 2–5 fill the FIFO, and no `DROP` occurs. A sixth result → `DROP` pulses once. Draining yields results 1..5 in order, 10 bytes.
- **Push on full with simultaneous pop:** FIFO full, final `TX_READY` handshake coincident with `OUT_VALID` → no `DROP`, occupancy stays `DEPTH`.
- **Reset mid-stream:** assert `RST` while the MSB of 0x5678 is pending → `TX_VALID`=0 immediately, `EMPTY`=1, and no further bytes after release.
- **Tagging (`ALU_RSP_TAG_EN` defined):** `ALU_FUN`=4'b0010, `ALU_OUT`=0x00C8 → bytes 0xA2, 0xC8, 0x00.
